// File: rtl/mult_err_stats.sv
// Error-statistics collector for an approximate 16x16 signed multiplier: compares each
// approximate product against the exact one and accumulates error metrics over a fixed window.
module mult_err_stats #(
  parameter int N_SAMPLES = 1024,
  parameter int ACC_W     = 48,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clear,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [15:0]      i_a,
  input  logic signed [15:0]      i_b,
  input  logic signed [31:0]      i_z,
  output logic [CNT_W-1:0]        o_sample_cnt,
  output logic [CNT_W-1:0]        o_err_cnt,
  output logic [ACC_W-1:0]        o_sum_abs_err,
  output logic [32:0]             o_max_abs_err,
  output logic [ACC_W-1:0]        o_mean_abs_err,
  output logic                    o_done,
  output logic [1:0]              o_dbg_state
);

  localparam int               LOG2N = $clog2(N_SAMPLES);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_SAMPLES);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [32:0]        max_q, max_d;
  logic               s1_v_q, s1_v_d;
  logic signed [31:0] s1_exact_q, s1_exact_d;
  logic signed [31:0] s1_z_q, s1_z_d;
  logic               s2_v_q, s2_v_d;
  logic [32:0]        s2_abs_q, s2_abs_d;
  logic               s2_nz_q, s2_nz_d;

  logic               accept;
  logic signed [31:0] prod;
  logic signed [32:0] diff;
  logic [32:0]        abs_diff;
  logic [ACC_W:0]     sum_ext;

  // Handshake: a sample transfers on a cycle where i_valid and o_ready are both high;
  // o_ready depends only on registered state, never on i_valid.
  assign o_ready  = (state_q == ST_RUN) && (cnt_q < N_CNT);
  assign accept   = i_valid && o_ready;

  // Full-range signed product fits in 32 bits; the difference needs 33 to avoid overflow.
  assign prod     = i_a * i_b;
  assign diff     = {s1_z_q[31], s1_z_q} - {s1_exact_q[31], s1_exact_q};
  assign abs_diff = diff[32] ? 33'(-diff) : 33'(diff);
  assign sum_ext  = {1'b0, sum_q} + {{(ACC_W - 32){1'b0}}, s2_abs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    sum_d      = sum_q;
    max_d      = max_q;
    s1_v_d     = accept;
    s1_exact_d = s1_exact_q;
    s1_z_d     = s1_z_q;
    s2_v_d     = s1_v_q;
    s2_abs_d   = s2_abs_q;
    s2_nz_d    = s2_nz_q;

    if (accept) begin
      s1_exact_d = prod;
      s1_z_d     = i_z;
    end
    if (s1_v_q) begin
      s2_abs_d = abs_diff;
      s2_nz_d  = (diff != 33'sd0);
    end
    if (s2_v_q) begin
      sum_d     = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      err_cnt_d = err_cnt_q + CNT_W'(s2_nz_q);
      if (s2_abs_q > max_q) max_d = s2_abs_q;
    end

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == N_CNT - 1'b1) state_d = ST_DRAIN;
        end
      end
      // With no new input, S2 empties on the same edge that S1 empties into it.
      ST_DRAIN: if (!s1_v_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase

    if (i_clear) begin
      state_d   = ST_RUN;
      cnt_d     = '0;
      err_cnt_d = '0;
      sum_d     = '0;
      max_d     = '0;
      s1_v_d    = 1'b0;
      s2_v_d    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      sum_q      <= '0;
      max_q      <= '0;
      s1_v_q     <= 1'b0;
      s1_exact_q <= '0;
      s1_z_q     <= '0;
      s2_v_q     <= 1'b0;
      s2_abs_q   <= '0;
      s2_nz_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      sum_q      <= sum_d;
      max_q      <= max_d;
      s1_v_q     <= s1_v_d;
      s1_exact_q <= s1_exact_d;
      s1_z_q     <= s1_z_d;
      s2_v_q     <= s2_v_d;
      s2_abs_q   <= s2_abs_d;
      s2_nz_q    <= s2_nz_d;
    end
  end

  assign o_sample_cnt   = cnt_q;
  assign o_err_cnt      = err_cnt_q;
  assign o_sum_abs_err  = sum_q;
  assign o_max_abs_err  = max_q;
  assign o_mean_abs_err = sum_q >> LOG2N;
  assign o_done         = (state_q == ST_DONE);
  assign o_dbg_state    = state_q;

endmodule

// File: tb/tb_mult_err_stats.sv
// Directed bench for mult_err_stats with a 4-sample window and hand-computed statistics.
module tb_mult_err_stats;

  localparam int N     = 4;
  localparam int ACC_W = 40;
  localparam int CNT_W = $clog2(N + 1);

  logic               i_clk, i_rst, i_clear, i_valid;
  logic               o_ready, o_done;
  logic signed [15:0] i_a, i_b;
  logic signed [31:0] i_z;
  logic [CNT_W-1:0]   o_sample_cnt, o_err_cnt;
  logic [ACC_W-1:0]   o_sum_abs_err, o_mean_abs_err;
  logic [32:0]        o_max_abs_err;
  logic [1:0]         o_dbg_state;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];

  logic signed [15:0] va[N];
  logic signed [15:0] vb[N];
  logic signed [31:0] vz[N];

  mult_err_stats #(.N_SAMPLES(N), .ACC_W(ACC_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid),
    .o_ready(o_ready), .i_a(i_a), .i_b(i_b), .i_z(i_z),
    .o_sample_cnt(o_sample_cnt), .o_err_cnt(o_err_cnt),
    .o_sum_abs_err(o_sum_abs_err), .o_max_abs_err(o_max_abs_err),
    .o_mean_abs_err(o_mean_abs_err), .o_done(o_done), .o_dbg_state(o_dbg_state)
  );

  // Clock and reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_stats(input logic [63:0] err, input logic [63:0] sum,
                              input logic [63:0] mx, input logic [63:0] mean);
    exp_q.push_back(err);
    exp_q.push_back(sum);
    exp_q.push_back(mx);
    exp_q.push_back(mean);
  endtask

  task automatic check_stats(input string tag);
    logic [63:0] e;
    e = exp_q.pop_front(); check({tag, "_err_cnt"}, 64'(o_err_cnt), e);
    e = exp_q.pop_front(); check({tag, "_sum"},     64'(o_sum_abs_err), e);
    e = exp_q.pop_front(); check({tag, "_max"},     64'(o_max_abs_err), e);
    e = exp_q.pop_front(); check({tag, "_mean"},    64'(o_mean_abs_err), e);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cnt"},   64'(o_sample_cnt), 64'd0);
    check({tag, "_err"},   64'(o_err_cnt), 64'd0);
    check({tag, "_sum"},   64'(o_sum_abs_err), 64'd0);
    check({tag, "_max"},   64'(o_max_abs_err), 64'd0);
    check({tag, "_done"},  64'(o_done), 64'd0);
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic signed [15:0] a,
                         input logic signed [15:0] b, input logic signed [31:0] z);
    va[i] = a; vb[i] = b; vz[i] = z;
  endtask

  // Drives the stored vectors back to back, then checks the window-end timing.
  task automatic run_window(input string tag);
    for (int i = 0; i < N; i++) begin
      i_valid = 1'b1; i_a = va[i]; i_b = vb[i]; i_z = vz[i];
      tick();
      if (i == 0) check({tag, "_cnt_after_first"}, 64'(o_sample_cnt), 64'd1);
    end
    i_valid = 1'b0;
    check({tag, "_ready_t1"}, 64'(o_ready), 64'd0);
    check({tag, "_cnt_t1"},   64'(o_sample_cnt), 64'(N));
    check({tag, "_done_t1"},  64'(o_done), 64'd0);
    tick();
    check({tag, "_done_t2"},  64'(o_done), 64'd0);
    tick();
    check({tag, "_done_t3"},  64'(o_done), 64'd1);
  endtask

  task automatic load_mixed();
    set_vec(0, 16'sd3, 16'sd5, 32'sd14);
    set_vec(1, -16'sd2, 16'sd100, -32'sd190);
    set_vec(2, 16'sd1, 16'sd1, 32'sd1);
    set_vec(3, 16'sd10, 16'sd10, 32'sd100);
  endtask

  int acc_n;

  initial begin
    i_rst = 1'b1; i_clear = 1'b0; i_valid = 1'b0;
    i_a = '0; i_b = '0; i_z = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    tick();

    // Reset state
    check_cleared("reset");
    check("reset_state", 64'(o_dbg_state), 64'd0);
    check("reset_mean", 64'(o_mean_abs_err), 64'd0);

    // Exact stream: no error at all
    set_vec(0, 16'sd3, 16'sd5, 32'sd15);
    set_vec(1, -16'sd7, 16'sd9, -32'sd63);
    set_vec(2, 16'sd0, -16'sd1, 32'sd0);
    set_vec(3, 16'sd32767, 16'sd32767, 32'sd1073676289);
    run_window("exact");
    expect_stats(0, 0, 0, 0);
    check_stats("exact");

    // Mixed errors: |diff| = 1, 10, 0, 0
    do_clear();
    check_cleared("clear1");
    load_mixed();
    run_window("mixed");
    expect_stats(2, 11, 10, 2);
    check_stats("mixed");

    // Extreme difference: -2^31 - 2^30 needs the 33rd bit
    do_clear();
    set_vec(0, -16'sd32768, -16'sd32768, 32'sh8000_0000);
    for (int i = 1; i < N; i++) set_vec(i, 16'sd0, 16'sd0, 32'sd0);
    run_window("extreme");
    expect_stats(1, 64'd3221225472, 64'h0_C000_0000, 64'd805306368);
    check_stats("extreme");

    // Backpressure: valid held far longer than the window, each sample off by one
    do_clear();
    acc_n = 0;
    i_valid = 1'b1; i_a = 16'sd1; i_b = 16'sd2; i_z = 32'sd3;
    for (int i = 0; i < N + 5; i++) begin
      if (o_ready) acc_n++;
      if (i == N) check("bp_ready_fall", 64'(o_ready), 64'd0);
      tick();
    end
    check("bp_accepted", 64'(acc_n), 64'(N));
    check("bp_done", 64'(o_done), 64'd1);
    expect_stats(4, 4, 1, 1);
    check_stats("bp");
    repeat (3) tick();
    i_valid = 1'b0;
    check("bp_frozen_cnt", 64'(o_sample_cnt), 64'(N));
    expect_stats(4, 4, 1, 1);
    check_stats("bp_frozen");

    // Clear colliding with a valid sample after two accepted samples
    do_clear();
    load_mixed();
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_a = va[i]; i_b = vb[i]; i_z = vz[i];
      tick();
    end
    i_clear = 1'b1; i_a = 16'sd1; i_b = 16'sd1; i_z = 32'sd5;
    tick();
    i_clear = 1'b0; i_valid = 1'b0;
    check_cleared("collide");
    repeat (3) tick();
    check("collide_late_cnt", 64'(o_sample_cnt), 64'd0);
    check("collide_late_sum", 64'(o_sum_abs_err), 64'd0);
    check("collide_late_err", 64'(o_err_cnt), 64'd0);
    i_valid = 1'b1; i_a = 16'sd1; i_b = 16'sd1; i_z = 32'sd2;
    tick();
    i_valid = 1'b0;
    check("collide_next_cnt", 64'(o_sample_cnt), 64'd1);
    tick(); tick();
    expect_stats(1, 1, 1, 0);
    check_stats("collide_next");

    // Asynchronous reset while draining
    do_clear();
    load_mixed();
    for (int i = 0; i < N; i++) begin
      i_valid = 1'b1; i_a = va[i]; i_b = vb[i]; i_z = vz[i];
      tick();
    end
    i_valid = 1'b0;
    check("drain_state", 64'(o_dbg_state), 64'd1);
    check("drain_sum_nonzero", 64'(o_sum_abs_err != '0), 64'd1);
    #2 i_rst = 1'b1;
    #1;
    check("areset_cnt", 64'(o_sample_cnt), 64'd0);
    check("areset_sum", 64'(o_sum_abs_err), 64'd0);
    check("areset_max", 64'(o_max_abs_err), 64'd0);
    check("areset_ready", 64'(o_ready), 64'd1);
    check("areset_state", 64'(o_dbg_state), 64'd0);
    i_rst = 1'b0;
    tick();
    run_window("post_reset");
    expect_stats(2, 11, 10, 2);
    check_stats("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
